// File: rtl/ps2_keycode_source.sv
// rtl/ps2_keycode_source.sv - PS/2 keyboard frame receiver producing keycode/keyPress for game logic
//
// Ports:
//   Clk       system clock, rising edge
//   Reset     synchronous, active-high
//   ps2_clk   raw PS/2 clock pin (asynchronous)
//   ps2_data  raw PS/2 data pin (asynchronous)
//   keycode   last accepted scan code (make or break target)
//   keyPress  high while the key in keycode is held
//   keyValid  one-cycle pulse when keycode/keyPress update
//   frameErr  one-cycle pulse on start, parity, stop or timeout error
//
// Build option: PS2_EXTENDED_EN - decode E0-prefixed codes like normal codes
//   (the E0 is dropped, so arrow keys alias keypad keys); when undefined,
//   scan codes completed after an E0 prefix are discarded.

module ps2_keycode_source #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] keycode,
    output logic       keyPress,
    output logic       keyValid,
    output logic       frameErr
);

    localparam logic [16:0] TIMEOUT_LIMIT = 17'(TIMEOUT_CYCLES);
    localparam logic [7:0]  BREAK_PREFIX  = 8'hF0;
    localparam logic [7:0]  EXT_PREFIX    = 8'hE0;

`ifdef PS2_EXTENDED_EN
    localparam logic EXT_DECODE = 1'b1;
`else
    localparam logic EXT_DECODE = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } frame_state_t;

    frame_state_t state;

    // Two-flop synchronisers; index 1 is the synchronised value.
    logic [1:0]  clk_sync;
    logic [1:0]  data_sync;
    logic        clk_prev;
    logic        ps2_fall;
    logic        data_bit;

    logic [7:0]  shift_reg;
    logic [2:0]  bit_cnt;
    logic        parity_ok;
    logic        brk;
    logic        ext;
    logic [16:0] timeout_cnt;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
            clk_prev  <= clk_sync[1];
        end
    end

    assign ps2_fall = clk_prev & ~clk_sync[1];
    assign data_bit = data_sync[1];

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= IDLE;
            shift_reg   <= '0;
            bit_cnt     <= '0;
            parity_ok   <= 1'b0;
            brk         <= 1'b0;
            ext         <= 1'b0;
            timeout_cnt <= '0;
            keycode     <= 8'h00;
            keyPress    <= 1'b0;
            keyValid    <= 1'b0;
            frameErr    <= 1'b0;
        end else begin
            keyValid <= 1'b0;
            frameErr <= 1'b0;

            if (state == IDLE || ps2_fall) begin
                timeout_cnt <= '0;
            end else begin
                timeout_cnt <= timeout_cnt + 17'd1;
            end

            case (state)
                IDLE: begin
                    if (ps2_fall) begin
                        if (!data_bit) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end else begin
                            // A falling edge with data high cannot be a start bit.
                            frameErr <= 1'b1;
                            brk      <= 1'b0;
                            ext      <= 1'b0;
                        end
                    end
                end

                DATA: begin
                    if (ps2_fall) begin
                        // LSB arrives first, so shift right and insert at the top.
                        shift_reg <= {data_bit, shift_reg[7:1]};
                        bit_cnt   <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= PARITY;
                        end
                    end
                end

                PARITY: begin
                    if (ps2_fall) begin
                        // Odd parity: data plus parity bit carry an odd count of ones.
                        parity_ok <= ^{shift_reg, data_bit};
                        state     <= STOP;
                    end
                end

                STOP: begin
                    if (ps2_fall) begin
                        state <= IDLE;
                        if (parity_ok && data_bit) begin
                            if (shift_reg == BREAK_PREFIX) begin
                                brk <= 1'b1;
                            end else if (shift_reg == EXT_PREFIX) begin
                                ext <= 1'b1;
                            end else begin
                                brk <= 1'b0;
                                ext <= 1'b0;
                                if (!ext || EXT_DECODE) begin
                                    if (!brk) begin
                                        keycode  <= shift_reg;
                                        keyPress <= 1'b1;
                                        keyValid <= 1'b1;
                                    end else if (shift_reg == keycode) begin
                                        // Releases of keys other than the held one are ignored.
                                        keyPress <= 1'b0;
                                        keyValid <= 1'b1;
                                    end
                                end
                            end
                        end else begin
                            frameErr <= 1'b1;
                            brk      <= 1'b0;
                            ext      <= 1'b0;
                        end
                    end
                end

                default: state <= IDLE;
            endcase

            // Abandon a stalled frame; a coincident edge takes priority.
            if (state != IDLE && !ps2_fall && timeout_cnt == TIMEOUT_LIMIT) begin
                state     <= IDLE;
                frameErr  <= 1'b1;
                brk       <= 1'b0;
                ext       <= 1'b0;
                shift_reg <= '0;
                bit_cnt   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_keycode_source.sv
// tb/tb_ps2_keycode_source.sv - directed self-checking bench for ps2_keycode_source

module tb_ps2_keycode_source;

    localparam int TIMEOUT = 300;
    localparam int HALF    = 10;

`ifdef PS2_EXTENDED_EN
    localparam logic EXT = 1'b1;
`else
    localparam logic EXT = 1'b0;
`endif

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] keycode;
    logic       keyPress;
    logic       keyValid;
    logic       frameErr;

    int n_cmp = 0;
    int n_err = 0;
    int kv_cnt = 0;
    int fe_cnt = 0;
    int overlap = 0;
    int stretch = 0;
    logic kv_prev = 1'b0;
    logic fe_prev = 1'b0;

    ps2_keycode_source #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .keycode  (keycode),
        .keyPress (keyPress),
        .keyValid (keyValid),
        .frameErr (frameErr)
    );

    always #5 Clk = ~Clk;

    always @(negedge Clk) begin
        if (keyValid) kv_cnt++;
        if (frameErr) fe_cnt++;
        if (keyValid && frameErr) overlap++;
        if ((keyValid && kv_prev) || (frameErr && fe_prev)) stretch++;
        kv_prev = keyValid;
        fe_prev = frameErr;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_counts();
        @(posedge Clk);
        kv_cnt = 0;
        fe_cnt = 0;
        @(negedge Clk);
    endtask

    task automatic send_bit(input logic b);
        ps2_data = b;
        repeat (HALF) @(negedge Clk);
        ps2_clk = 1'b0;
        repeat (HALF) @(negedge Clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par_good, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(par_good ? ~^b : ^b);
        send_bit(stop);
        ps2_data = 1'b1;
        repeat (8) @(negedge Clk);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge Clk);
        check("rst_keycode", keycode, 8'h00);
        check("rst_keyPress", keyPress, 1'b0);
        check("rst_keyValid", keyValid, 1'b0);
        check("rst_frameErr", frameErr, 1'b0);
        Reset = 1'b0;
        repeat (5) @(negedge Clk);

        // Make code W
        clear_counts();
        send_frame(8'h1D, 1'b1, 1'b1);
        check("make_keycode", keycode, 8'h1D);
        check("make_keyPress", keyPress, 1'b1);
        check("make_kv_pulses", kv_cnt, 1);
        check("make_fe_pulses", fe_cnt, 0);

        // Break prefix alone changes nothing
        clear_counts();
        send_frame(8'hF0, 1'b1, 1'b1);
        check("f0_keyPress", keyPress, 1'b1);
        check("f0_keycode", keycode, 8'h1D);
        check("f0_kv_pulses", kv_cnt, 0);

        // Matching break releases the key
        send_frame(8'h1D, 1'b1, 1'b1);
        check("brk_keyPress", keyPress, 1'b0);
        check("brk_keycode", keycode, 8'h1D);
        check("brk_kv_pulses", kv_cnt, 1);

        // Break for a different key leaves the held key alone
        send_frame(8'h1D, 1'b1, 1'b1);
        clear_counts();
        send_frame(8'hF0, 1'b1, 1'b1);
        send_frame(8'h1C, 1'b1, 1'b1);
        check("brk_other_keyPress", keyPress, 1'b1);
        check("brk_other_keycode", keycode, 8'h1D);
        check("brk_other_kv_pulses", kv_cnt, 0);

        // Typematic repeat
        clear_counts();
        send_frame(8'h1D, 1'b1, 1'b1);
        check("repeat_kv_pulses", kv_cnt, 1);
        check("repeat_keyPress", keyPress, 1'b1);

        // Bad parity, then a valid code
        clear_counts();
        send_frame(8'h1D, 1'b0, 1'b1);
        check("par_fe_pulses", fe_cnt, 1);
        check("par_kv_pulses", kv_cnt, 0);
        check("par_keycode", keycode, 8'h1D);
        clear_counts();
        send_frame(8'h1B, 1'b1, 1'b1);
        check("after_par_keycode", keycode, 8'h1B);
        check("after_par_keyPress", keyPress, 1'b1);
        check("after_par_fe_pulses", fe_cnt, 0);

        // A frame error cancels a pending break prefix
        clear_counts();
        send_frame(8'hF0, 1'b1, 1'b1);
        send_frame(8'h55, 1'b0, 1'b1);
        send_frame(8'h1B, 1'b1, 1'b1);
        check("err_clr_brk_keyPress", keyPress, 1'b1);
        check("err_clr_brk_kv_pulses", kv_cnt, 1);
        check("err_clr_brk_fe_pulses", fe_cnt, 1);

        // Bad stop bit and bad start bit
        clear_counts();
        send_frame(8'h1D, 1'b1, 1'b0);
        check("stop_fe_pulses", fe_cnt, 1);
        check("stop_keycode", keycode, 8'h1B);
        clear_counts();
        send_bit(1'b1);
        repeat (8) @(negedge Clk);
        check("start_fe_pulses", fe_cnt, 1);
        check("start_kv_pulses", kv_cnt, 0);

        // Timeout mid-frame
        clear_counts();
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        repeat (TIMEOUT + 5) @(negedge Clk);
        check("timeout_fe_pulses", fe_cnt, 1);
        check("timeout_kv_pulses", kv_cnt, 0);
        clear_counts();
        send_frame(8'h29, 1'b1, 1'b1);
        check("after_to_keycode", keycode, 8'h29);
        check("after_to_kv_pulses", kv_cnt, 1);
        check("after_to_fe_pulses", fe_cnt, 0);

        // Extended make and break
        clear_counts();
        send_frame(8'hE0, 1'b1, 1'b1);
        send_frame(8'h75, 1'b1, 1'b1);
        check("ext_make_keycode", keycode, EXT ? 8'h75 : 8'h29);
        check("ext_make_keyPress", keyPress, 1'b1);
        check("ext_make_kv_pulses", kv_cnt, EXT ? 1 : 0);
        clear_counts();
        send_frame(8'hE0, 1'b1, 1'b1);
        send_frame(8'hF0, 1'b1, 1'b1);
        send_frame(8'h75, 1'b1, 1'b1);
        check("ext_brk_keycode", keycode, EXT ? 8'h75 : 8'h29);
        check("ext_brk_keyPress", keyPress, EXT ? 1'b0 : 1'b1);
        check("ext_brk_kv_pulses", kv_cnt, EXT ? 1 : 0);
        clear_counts();
        send_frame(8'h75, 1'b1, 1'b1);
        check("post_ext_keycode", keycode, 8'h75);
        check("post_ext_keyPress", keyPress, 1'b1);
        check("post_ext_kv_pulses", kv_cnt, 1);

        // Reset mid-frame
        clear_counts();
        send_bit(1'b0);
        for (int i = 0; i < 5; i++) send_bit(i[0]);
        repeat (4) @(negedge Clk);
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        check("midrst_keycode", keycode, 8'h00);
        check("midrst_keyPress", keyPress, 1'b0);
        check("midrst_keyValid", keyValid, 1'b0);
        check("midrst_frameErr", frameErr, 1'b0);
        @(negedge Clk);
        Reset = 1'b0;
        repeat (5) @(negedge Clk);
        clear_counts();
        send_frame(8'h1D, 1'b1, 1'b1);
        check("after_rst_keycode", keycode, 8'h1D);
        check("after_rst_keyPress", keyPress, 1'b1);
        check("after_rst_kv_pulses", kv_cnt, 1);
        check("after_rst_fe_pulses", fe_cnt, 0);

        // Pulse shape over the whole run
        check("pulse_overlap", overlap, 0);
        check("pulse_stretch", stretch, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
